// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : Multi-cycle instruction sequencer. Walks
//               IDLE -> FETCH -> DECODE -> EXEC -> WB and issues one
//               write-back / PC strobe per instruction in WB.
//               Throughput is one instruction per 4 cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : PW           register pointer width (operand port is PW+1 bits)
// Ports       : clk          clock, rising edge
//               reset        synchronous, active-high
//               start        begin execution (honoured in IDLE only)
//               instr[8:0]   instruction word {opcode[3:0], operand[4:0]}
//               acc_zero     accumulator r0 reads zero (sampled in EXEC)
//               reg_write    r0 write-back strobe (ALU ops, GET)
//               reg_set      r0 -> r[op_reg_addr] copy strobe (SET)
//               lut_set      LUT target -> r0 load strobe (LUT)
//               op_reg_addr  operand register pointer, valid DECODE..WB
//               alu_op       ALU function select, valid DECODE..WB
//               pc_inc       program counter +1 strobe
//               branch_take  program counter load-from-LUT strobe
//               busy         high outside IDLE and HALT
//               halted       high in HALT
//               instr_cnt    retired instruction count, saturating
//               illegal      (CTRL_ILLEGAL_TRAP_EN only) undefined-opcode trap
// Build macro : CTRL_ILLEGAL_TRAP_EN - undefined opcodes trap into HALT and
//               raise illegal; when undefined they retire as NOPs.
// ============================================================================
module ctrl_fsm #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [8:0]    instr,
    input  logic          acc_zero,
    output logic          reg_write,
    output logic          reg_set,
    output logic          lut_set,
    output logic [PW:0]   op_reg_addr,
    output logic [3:0]    alu_op,
    output logic          pc_inc,
    output logic          branch_take,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   instr_cnt
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic          illegal
`endif
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [3:0] c_OP_SHR  = 4'b0101;
    localparam logic [3:0] c_OP_SET  = 4'b0110;
    localparam logic [3:0] c_OP_GET  = 4'b0111;
    localparam logic [3:0] c_OP_LUT  = 4'b1000;
    localparam logic [3:0] c_OP_BZ   = 4'b1001;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    logic [2:0]  r_state;
    logic [8:0]  r_ir;
    logic        r_fld_valid;   // operand fields presented to the datapath
    logic        r_reg_write;
    logic        r_reg_set;
    logic        r_lut_set;
    logic        r_pc_inc;
    logic        r_branch_take;
    logic        r_busy;
    logic        r_halted;
    logic [15:0] r_instr_cnt;

    // Decode of the latched instruction only.
    logic [3:0]  w_opcode;
    logic        w_is_alu;
    logic        w_is_get;
    logic        w_is_set;
    logic        w_is_lut;
    logic        w_is_bz;
    logic        w_is_halt;
    logic        w_trap;
    logic [3:0]  w_alu_sel;

    assign w_opcode  = r_ir[8:5];
    assign w_is_alu  = (w_opcode <= c_OP_SHR);
    assign w_is_get  = (w_opcode == c_OP_GET);
    assign w_is_set  = (w_opcode == c_OP_SET);
    assign w_is_lut  = (w_opcode == c_OP_LUT);
    assign w_is_bz   = (w_opcode == c_OP_BZ);
    assign w_is_halt = (w_opcode == c_OP_HALT);
    assign w_alu_sel = (w_is_alu || w_is_get) ? w_opcode : 4'd0;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_is_undef;
    assign w_is_undef = (w_opcode >= 4'b1010) && (w_opcode <= 4'b1110);
    assign w_trap     = w_is_undef;
    assign illegal    = r_illegal;
`else
    // Undefined opcodes fall through every decode term and retire as NOPs.
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_ir          <= 9'd0;
            r_fld_valid   <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_set     <= 1'b0;
            r_lut_set     <= 1'b0;
            r_pc_inc      <= 1'b0;
            r_branch_take <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_cnt   <= 16'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; only the EXEC->WB edge raises them.
            r_reg_write   <= 1'b0;
            r_reg_set     <= 1'b0;
            r_lut_set     <= 1'b0;
            r_pc_inc      <= 1'b0;
            r_branch_take <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    r_ir        <= instr;
                    r_fld_valid <= 1'b1;
                    r_state     <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_state <= c_ST_EXEC;
                end
                c_ST_EXEC: begin
                    // Strobes are registered here so they are visible in WB.
                    r_state       <= c_ST_WB;
                    r_reg_write   <= w_is_alu || w_is_get;
                    r_reg_set     <= w_is_set;
                    r_lut_set     <= w_is_lut;
                    r_branch_take <= w_is_bz && acc_zero;
                    r_pc_inc      <= !w_is_halt && !w_trap && !(w_is_bz && acc_zero);
                    if (r_instr_cnt != 16'hFFFF) begin
                        r_instr_cnt <= r_instr_cnt + 16'd1;
                    end
                end
                c_ST_WB: begin
                    r_fld_valid <= 1'b0;
                    if (w_is_halt || w_trap) begin
                        r_state  <= c_ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        r_illegal <= w_trap;
`endif
                    end else begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_busy      <= 1'b0;
                    r_fld_valid <= 1'b0;
                end
            endcase
        end
    end

    // Reset masks the strobes in the very cycle it is asserted, so a reset
    // landing on WB never produces a partial write-back.
    assign reg_write   = r_reg_write   & ~reset;
    assign reg_set     = r_reg_set     & ~reset;
    assign lut_set     = r_lut_set     & ~reset;
    assign pc_inc      = r_pc_inc      & ~reset;
    assign branch_take = r_branch_take & ~reset;

    assign op_reg_addr = r_fld_valid ? (PW+1)'(r_ir[4:0]) : '0;
    assign alu_op      = r_fld_valid ? w_alu_sel : 4'd0;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign instr_cnt   = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Self-checking bench for ctrl_fsm. A cycle-level behavioural
//               model predicts all outputs every cycle; directed sequences
//               add literal expectations, followed by randomized traffic.
// Revision    : 1.0 - initial release
// Build macro : CTRL_ILLEGAL_TRAP_EN selects the trapping variant.
// ============================================================================
module tb_ctrl_fsm;

    localparam int PW = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [8:0]    instr;
    logic          acc_zero;
    logic          reg_write;
    logic          reg_set;
    logic          lut_set;
    logic [PW:0]   op_reg_addr;
    logic [3:0]    alu_op;
    logic          pc_inc;
    logic          branch_take;
    logic          busy;
    logic          halted;
    logic [15:0]   instr_cnt;
    logic          w_dut_ill;

    int vectors = 0;
    int miscompares = 0;

    ctrl_fsm #(.PW(PW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .acc_zero    (acc_zero),
        .reg_write   (reg_write),
        .reg_set     (reg_set),
        .lut_set     (lut_set),
        .op_reg_addr (op_reg_addr),
        .alu_op      (alu_op),
        .pc_inc      (pc_inc),
        .branch_take (branch_take),
        .busy        (busy),
        .halted      (halted),
        .instr_cnt   (instr_cnt)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal     (w_dut_ill)
`endif
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign w_dut_ill = 1'b0;
`endif

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_pos: -1 = not executing, otherwise cycles elapsed since this
    // instruction's fetch cycle (0 fetch .. 3 write-back).
    int          m_pos  = -1;
    bit          m_halt = 1'b0;
    bit          m_ill  = 1'b0;
    logic [8:0]  m_ir   = 9'd0;
    bit          m_z    = 1'b0;
    int unsigned m_cnt  = 0;

    function automatic bit is_undef(input logic [3:0] op);
        return (op >= 4'd10) && (op <= 4'd14);
    endfunction

    function automatic logic [39:0] model_out();
        logic [3:0] op;
        bit wb, rw, rs, ls, bt, pc;
        logic [4:0] ora;
        logic [3:0] alu;
        op  = m_ir[8:5];
        wb  = (m_pos == 3) && !reset;
        rw  = wb && (op <= 4'd5 || op == 4'd7);
        rs  = wb && (op == 4'd6);
        ls  = wb && (op == 4'd8);
        bt  = wb && (op == 4'd9) && m_z;
        pc  = wb && (op != 4'd15) && !(c_TRAP && is_undef(op)) && !((op == 4'd9) && m_z);
        ora = (m_pos >= 1) ? m_ir[4:0] : 5'd0;
        alu = ((m_pos >= 1) && (op <= 4'd5 || op == 4'd7)) ? op : 4'd0;
        return {7'd0, rw, rs, ls, pc, bt, (m_pos >= 0), m_halt, m_ill, ora, alu, m_cnt[15:0]};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pos = -1; m_halt = 1'b0; m_ill = 1'b0; m_ir = 9'd0; m_cnt = 0;
        end else if (!m_halt) begin
            case (m_pos)
                -1: if (start) m_pos = 0;
                0: begin m_ir = instr; m_pos = 1; end
                1: m_pos = 2;
                2: begin
                    m_z = acc_zero;
                    if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
                    m_pos = 3;
                end
                default: begin
                    if (m_ir[8:5] == 4'd15 || (c_TRAP && is_undef(m_ir[8:5]))) begin
                        m_halt = 1'b1;
                        m_ill  = c_TRAP && is_undef(m_ir[8:5]);
                        m_pos  = -1;
                    end else begin
                        m_pos = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: compare on the falling edge, advance model on the rising edge.
    task automatic cycle();
        logic [39:0] e, a;
        @(negedge clk);
        e = model_out();
        a = {7'd0, reg_write, reg_set, lut_set, pc_inc, branch_take, busy, halted,
             w_dut_ill, op_reg_addr, alu_op, instr_cnt};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL cycle t=%0t dut=%h model=%h", $time, a, e);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called in FETCH: present the word, run until the WB cycle.
    task automatic run_instr(input logic [8:0] ins, input logic az);
        instr = ins;
        acc_zero = az;
        repeat (3) cycle();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr = 9'd0; acc_zero = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        cycle();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(instr_cnt), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);

        // ADD r3: strobe lands 4 cycles after start
        reset = 1'b0; start = 1'b1; instr = 9'b0000_00011;
        cycle();
        start = 1'b0;
        cycle();
        check("add_decode_rw", 32'(reg_write), 32'd0);
        cycle();
        check("add_exec_rw", 32'(reg_write), 32'd0);
        cycle();
        check("add_wb_rw", 32'(reg_write), 32'd1);
        check("add_wb_alu", 32'(alu_op), 32'd0);
        check("add_wb_addr", 32'(op_reg_addr), 32'd3);
        check("add_wb_pc", 32'(pc_inc), 32'd1);
        check("add_wb_cnt", 32'(instr_cnt), 32'd1);
        cycle();
        check("add_after_rw", 32'(reg_write), 32'd0);

        // SET r5 then LUT
        run_instr(9'b0110_00101, 1'b0);
        check("set_rs", 32'(reg_set), 32'd1);
        check("set_addr", 32'(op_reg_addr), 32'd5);
        check("set_ls", 32'(lut_set), 32'd0);
        cycle();
        run_instr(9'b1000_00000, 1'b0);
        check("lut_ls", 32'(lut_set), 32'd1);
        check("lut_rs", 32'(reg_set), 32'd0);
        cycle();

        // BZ taken, then BZ not taken
        run_instr(9'b1001_00000, 1'b1);
        check("bz1_bt", 32'(branch_take), 32'd1);
        check("bz1_pc", 32'(pc_inc), 32'd0);
        check("bz1_rw", 32'({reg_write, reg_set, lut_set}), 32'd0);
        cycle();
        run_instr(9'b1001_00000, 1'b0);
        check("bz0_bt", 32'(branch_take), 32'd0);
        check("bz0_pc", 32'(pc_inc), 32'd1);
        cycle();

        // undefined opcode 1010
        run_instr(9'b1010_00000, 1'b0);
        check("undef_cnt", 32'(instr_cnt), 32'd6);
        check("undef_pc", 32'(pc_inc), c_TRAP ? 32'd0 : 32'd1);
        cycle();
`ifndef CTRL_ILLEGAL_TRAP_EN
        run_instr(9'b1111_00000, 1'b0);
        check("halt_pc", 32'(pc_inc), 32'd0);
        check("halt_cnt", 32'(instr_cnt), 32'd7);
        cycle();
`endif
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_illegal", 32'(w_dut_ill), c_TRAP ? 32'd1 : 32'd0);

        // start held in HALT changes nothing
        start = 1'b1;
        repeat (10) cycle();
        start = 1'b0;
        check("halt_hold", 32'({busy, halted}), 32'b01);
        check("halt_hold_cnt", 32'(instr_cnt), c_TRAP ? 32'd6 : 32'd7);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_all", 32'({reg_write, reg_set, lut_set, pc_inc, branch_take, busy, halted, w_dut_ill}), 32'd0);
        check("rst_fields", 32'({op_reg_addr, alu_op, instr_cnt}), 32'd0);

        // reset during EXEC of ADD
        start = 1'b1; instr = 9'b0000_00001;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_cnt", 32'(instr_cnt), 32'd0);
        cycle();
        check("rst_exec_rw", 32'(reg_write), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 3) == 0);
            instr    = 9'($urandom_range(0, 511));
            acc_zero = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
